cfg_reg_file: RTL and testbench

Parametrised configuration/status register file, successor to the fixed 8x16 register bank. It serves the system controller over a request/response bus with response backpressure. It adds per-register read-only protection, per-register reset values, a hardware status-update port, error reporting, and a configurable number of exported registers that drive downstream blocks (ALU, UART, clock divider config).

---
 rtl/cfg_reg_pkg.sv | 20 ++
 rtl/cfg_rsp_slot.sv | 54 +++++
 rtl/cfg_reg_file.sv | 107 ++++++++++
 tb/tb_cfg_reg_file.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_reg_pkg.sv
// Shared constants for the configuration register file: error codes and the
// default system register map (ALU cfg, UART cfg, divider ratio, status).
package cfg_reg_pkg;

  localparam int unsigned ERR_W = 2;

  localparam logic [ERR_W-1:0] ERR_NONE  = 2'd0;
  localparam logic [ERR_W-1:0] ERR_RANGE = 2'd1;
  localparam logic [ERR_W-1:0] ERR_RO    = 2'd2;

  localparam int unsigned SYS_WIDTH = 8;
  localparam int unsigned SYS_DEPTH = 16;

  // Registers 0..3 (ALU cfg, UART cfg, div ratio, status) are bus read-only.
  localparam logic [SYS_DEPTH-1:0] SYS_RO_MASK = 16'h000F;

  localparam logic [SYS_DEPTH*SYS_WIDTH-1:0] SYS_RST_VALUES =
    {96'h0, 8'h00, 8'h20, 8'h00, 8'h81};

endpackage

// File: rtl/cfg_rsp_slot.sv
// Single-entry valid/ready response register for bus reads; also produces
// the request-ready signal, which is high whenever the slot can take a new entry.
module cfg_rsp_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  input  logic             rsp_ready_i,
  output logic             req_ready_c,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  assign req_ready_c = !valid_q || rsp_ready_i;

  // A load always wins; otherwise a consumed entry empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      err_d   = err_i;
    end else if (rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule

// File: rtl/cfg_reg_file.sv
// Parametrised configuration/status register file with bus request/response
// access, read-only protection, a hardware update port and exported registers.
module cfg_reg_file
  import cfg_reg_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned NUM_EXPORT    = 4,
  parameter logic [DEPTH-1:0]       RO_MASK    = '0,
  parameter logic [DEPTH*WIDTH-1:0] RST_VALUES = '0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WrEn,
  input  logic                          RdEn,
  input  logic [ADDRESS_WIDTH-1:0]      Address,
  input  logic [WIDTH-1:0]              WrData,
  output logic                          Req_Ready,
  output logic [WIDTH-1:0]              RdData,
  output logic                          RdData_Valid,
  input  logic                          RdData_Ready,
  output logic                          RdData_Err,
  output logic                          Wr_Err,
  input  logic                          HW_WrEn,
  input  logic [ADDRESS_WIDTH-1:0]      HW_Address,
  input  logic [WIDTH-1:0]              HW_WrData,
  output logic [NUM_EXPORT*WIDTH-1:0]   REG_OUT
);

  localparam int unsigned AW1   = ADDRESS_WIDTH + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] reg_q [DEPTH];
  logic [WIDTH-1:0] reg_d [DEPTH];
  logic [DEPTH-1:0] bus_hit;
  logic [DEPTH-1:0] hw_sel;

  logic             req_ready;
  logic             bus_in_range;
  logic             wr_acc, rd_acc, wr_ok;
  logic             ro_hit, hw_collide;
  logic [ERR_W-1:0] wr_code, rd_code;
  logic [WIDTH-1:0] rd_data;
  logic             wr_err_q, wr_err_d;

  assign bus_in_range = ({1'b0, Address} < AW1'(DEPTH));
  assign wr_acc       = WrEn && req_ready;
  assign rd_acc       = RdEn && !WrEn && req_ready;
  assign ro_hit       = |(bus_hit & RO_MASK);
  assign hw_collide   = |(bus_hit & hw_sel);
  assign wr_ok        = wr_acc && bus_in_range && !ro_hit;

  // Per-register decode and storage; the hardware port overrides the bus.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    assign bus_hit[g] = (Address == ADDRESS_WIDTH'(g));
    assign hw_sel[g]  = HW_WrEn && (HW_Address == ADDRESS_WIDTH'(g));
    assign reg_d[g]   = hw_sel[g]              ? HW_WrData :
                        (wr_ok && bus_hit[g])  ? WrData    : reg_q[g];

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) reg_q[g] <= RST_VALUES[g*WIDTH +: WIDTH];
      else      reg_q[g] <= reg_d[g];
    end
  end

  // Rejected bus writes are silent when the HW port writes the same register.
  always_comb begin
    wr_code = ERR_NONE;
    if (wr_acc && !hw_collide) begin
      if (!bus_in_range) wr_code = ERR_RANGE;
      else if (ro_hit)   wr_code = ERR_RO;
    end
  end

  assign rd_code  = bus_in_range ? ERR_NONE : ERR_RANGE;
  assign rd_data  = bus_in_range ? reg_q[Address[IDX_W-1:0]] : '0;
  assign wr_err_d = (wr_code != ERR_NONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wr_err_q <= 1'b0;
    else      wr_err_q <= wr_err_d;
  end

  cfg_rsp_slot #(
    .WIDTH (WIDTH)
  ) u_rsp_slot (
    .clk         (CLK),
    .rst_n       (RST),
    .load_i      (rd_acc),
    .data_i      (rd_data),
    .err_i       (rd_code != ERR_NONE),
    .rsp_ready_i (RdData_Ready),
    .req_ready_c (req_ready),
    .rsp_valid_o (RdData_Valid),
    .rsp_data_o  (RdData),
    .rsp_err_o   (RdData_Err)
  );

  assign Req_Ready = req_ready;
  assign Wr_Err    = wr_err_q;

  for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
    assign REG_OUT[g*WIDTH +: WIDTH] = reg_q[g];
  end

endmodule

// File: tb/tb_cfg_reg_file.sv
// Scoreboard bench for cfg_reg_file: 12 registers, register 3 read-only,
// reset values reg0=0x81, reg2=0x20, reg7=0x5C.
module tb_cfg_reg_file;

  localparam logic [11:0] TB_RO  = 12'h008;
  localparam logic [95:0] TB_RST = 96'h00000000_5C000000_00200081;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WrEn, RdEn, RdData_Ready, HW_WrEn;
  logic [3:0]  Address, HW_Address;
  logic [7:0]  WrData, HW_WrData, RdData;
  logic        Req_Ready, RdData_Valid, RdData_Err, Wr_Err;
  logic [31:0] REG_OUT;

  exp_t       sb [$];
  logic [7:0] mdl [12];
  int         n_tests = 0;
  int         n_fail  = 0;

  cfg_reg_file #(
    .WIDTH(8), .DEPTH(12), .ADDRESS_WIDTH(4), .NUM_EXPORT(4),
    .RO_MASK(TB_RO), .RST_VALUES(TB_RST)
  ) dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .Req_Ready(Req_Ready), .RdData(RdData),
    .RdData_Valid(RdData_Valid), .RdData_Ready(RdData_Ready),
    .RdData_Err(RdData_Err), .Wr_Err(Wr_Err), .HW_WrEn(HW_WrEn),
    .HW_Address(HW_Address), .HW_WrData(HW_WrData), .REG_OUT(REG_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle();
    WrEn = 1'b0; RdEn = 1'b0; HW_WrEn = 1'b0; RdData_Ready = 1'b1;
    Address = '0; WrData = '0; HW_Address = '0; HW_WrData = '0;
  endtask

  task automatic model_reset();
    logic [95:0] rv;
    rv = TB_RST;
    for (int i = 0; i < 12; i++) mdl[i] = rv[i*8 +: 8];
  endtask

  function automatic logic [31:0] exp_regout();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic test_reset();
    idle();
    model_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_tests++;
    if (Req_Ready !== 1'b1 || RdData_Valid !== 1'b0 || RdData !== 8'h00 ||
        RdData_Err !== 1'b0 || Wr_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h err=%b werr=%b, expected 1 0 00 0 0",
               Req_Ready, RdData_Valid, RdData, RdData_Err, Wr_Err);
    end
    RST = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (REG_OUT !== 32'h0020_0081 || RdData_Valid !== 1'b0 || Req_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: reg_out=%h vld=%b rdy=%b, expected 00200081 0 1",
               REG_OUT, RdData_Valid, Req_Ready);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    idle(); WrEn = 1'b1; Address = 4'd5; WrData = 8'hA5; mdl[5] = 8'hA5;
    @(negedge CLK);
    idle(); RdEn = 1'b1; Address = 4'd5; sb.push_back('{data: mdl[5], err: 1'b0});
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL write_read: vld=%b data=%h err=%b, expected 1 %h %b",
               RdData_Valid, RdData, RdData_Err, e.data, e.err);
    end
    idle();
    @(negedge CLK);
    n_tests++;
    if (RdData_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_drop: vld=%b, expected 0", RdData_Valid);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    idle(); WrEn = 1'b1; Address = 4'd6; WrData = 8'h66; mdl[6] = 8'h66;
    @(negedge CLK);
    idle(); RdEn = 1'b1; Address = 4'd5; RdData_Ready = 1'b0;
    sb.push_back('{data: mdl[5], err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      RdEn = 1'b1; Address = 4'd6; RdData_Ready = 1'b0;
      #1;
      n_tests++;
      if (Req_Ready !== 1'b0 || RdData_Valid !== 1'b1 || RdData !== sb[0].data) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b data=%h, expected 0 1 %h",
                 k, Req_Ready, RdData_Valid, RdData, sb[0].data);
      end
    end
    @(negedge CLK);
    RdData_Ready = 1'b1;
    #1;
    e = sb.pop_front();
    n_tests++;
    if (Req_Ready !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%b data=%h err=%b, expected 1 %h %b",
               Req_Ready, RdData, RdData_Err, e.data, e.err);
    end
    sb.push_back('{data: mdl[6], err: 1'b0});
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL bp_next: vld=%b data=%h err=%b, expected 1 %h %b",
               RdData_Valid, RdData, RdData_Err, e.data, e.err);
    end
    idle();
    @(negedge CLK);
  endtask

  task automatic test_protect_range();
    exp_t e;
    idle(); WrEn = 1'b1; Address = 4'd3; WrData = 8'h11;
    @(negedge CLK);
    n_tests++;
    if (Wr_Err !== 1'b1 || REG_OUT !== exp_regout()) begin
      n_fail++;
      $display("FAIL ro_write: werr=%b reg_out=%h, expected 1 %h", Wr_Err, REG_OUT, exp_regout());
    end
    idle();
    @(negedge CLK);
    n_tests++;
    if (Wr_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL werr_pulse: werr=%b, expected 0", Wr_Err);
    end
    WrEn = 1'b1; Address = 4'd13; WrData = 8'h44;
    @(negedge CLK);
    n_tests++;
    if (Wr_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL range_write: werr=%b, expected 1", Wr_Err);
    end
    idle(); RdEn = 1'b1; Address = 4'd14; sb.push_back('{data: 8'h00, err: 1'b1});
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL range_read: vld=%b data=%h err=%b, expected 1 %h %b",
               RdData_Valid, RdData, RdData_Err, e.data, e.err);
    end
    idle(); HW_WrEn = 1'b1; HW_Address = 4'd3; HW_WrData = 8'h7E; mdl[3] = 8'h7E;
    @(negedge CLK);
    n_tests++;
    if (REG_OUT !== exp_regout() || Wr_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL hw_ro_write: reg_out=%h werr=%b, expected %h 0", REG_OUT, Wr_Err, exp_regout());
    end
    idle(); RdEn = 1'b1; Address = 4'd3; sb.push_back('{data: mdl[3], err: 1'b0});
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL hw_read_back: vld=%b data=%h err=%b, expected 1 %h %b",
               RdData_Valid, RdData, RdData_Err, e.data, e.err);
    end
    idle();
  endtask

  task automatic test_collisions();
    exp_t e;
    @(negedge CLK);
    WrEn = 1'b1; Address = 4'd4; WrData = 8'h01;
    HW_WrEn = 1'b1; HW_Address = 4'd4; HW_WrData = 8'h02; mdl[4] = 8'h02;
    @(negedge CLK);
    n_tests++;
    if (Wr_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_wr: werr=%b, expected 0", Wr_Err);
    end
    idle(); RdEn = 1'b1; Address = 4'd4;
    HW_WrEn = 1'b1; HW_Address = 4'd4; HW_WrData = 8'h33;
    sb.push_back('{data: mdl[4], err: 1'b0}); mdl[4] = 8'h33;
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data) begin
      n_fail++;
      $display("FAIL collide_rd_old: vld=%b data=%h, expected 1 %h", RdData_Valid, RdData, e.data);
    end
    idle(); RdEn = 1'b1; Address = 4'd4; sb.push_back('{data: mdl[4], err: 1'b0});
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data) begin
      n_fail++;
      $display("FAIL collide_rd_new: vld=%b data=%h, expected 1 %h", RdData_Valid, RdData, e.data);
    end
    idle(); WrEn = 1'b1; RdEn = 1'b1; Address = 4'd7; WrData = 8'h99; mdl[7] = 8'h99;
    @(negedge CLK);
    n_tests++;
    if (RdData_Valid !== 1'b0 || Wr_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_same: vld=%b werr=%b, expected 0 0", RdData_Valid, Wr_Err);
    end
    idle(); WrEn = 1'b1; Address = 4'd3; WrData = 8'h55;
    HW_WrEn = 1'b1; HW_Address = 4'd3; HW_WrData = 8'h3C; mdl[3] = 8'h3C;
    @(negedge CLK);
    n_tests++;
    if (Wr_Err !== 1'b0 || REG_OUT !== exp_regout()) begin
      n_fail++;
      $display("FAIL collide_ro: werr=%b reg_out=%h, expected 0 %h", Wr_Err, REG_OUT, exp_regout());
    end
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
          n_fail++;
          $display("FAIL b2b[%0d]: vld=%b data=%h err=%b, expected 1 %h %b",
                   i - 1, RdData_Valid, RdData, RdData_Err, e.data, e.err);
        end
      end
      idle(); RdEn = 1'b1; Address = 4'(4 + i);
      sb.push_back('{data: mdl[4 + i], err: 1'b0});
    end
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL b2b[3]: vld=%b data=%h err=%b, expected 1 %h %b",
               RdData_Valid, RdData, RdData_Err, e.data, e.err);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    exp_t e;
    @(negedge CLK);
    idle(); RdEn = 1'b1; Address = 4'd5; RdData_Ready = 1'b0;
    sb.push_back('{data: mdl[5], err: 1'b0});
    @(negedge CLK);
    idle(); RdData_Ready = 1'b0;
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== sb[0].data) begin
      n_fail++;
      $display("FAIL pre_reset_hold: vld=%b data=%h, expected 1 %h", RdData_Valid, RdData, sb[0].data);
    end
    #2 RST = 1'b0;
    #1;
    sb.delete();
    model_reset();
    n_tests++;
    if (RdData_Valid !== 1'b0 || Req_Ready !== 1'b1 || REG_OUT !== exp_regout()) begin
      n_fail++;
      $display("FAIL mid_reset: vld=%b rdy=%b reg_out=%h, expected 0 1 %h",
               RdData_Valid, Req_Ready, REG_OUT, exp_regout());
    end
    @(negedge CLK);
    RST = 1'b1;
    idle();
    @(negedge CLK);
    RdEn = 1'b1; Address = 4'd5; sb.push_back('{data: mdl[5], err: 1'b0});
    @(negedge CLK);
    e = sb.pop_front();
    n_tests++;
    if (RdData_Valid !== 1'b1 || RdData !== e.data || RdData_Err !== e.err) begin
      n_fail++;
      $display("FAIL post_reset_read: vld=%b data=%h err=%b, expected 1 %h %b",
               RdData_Valid, RdData, RdData_Err, e.data, e.err);
    end
    idle();
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_protect_range();
    test_collisions();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
